// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified MIPS memory port: bus widths and arbiter state codes.
package mips_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t BUSY_I = 2'd1;
  localparam state_t BUSY_D = 2'd2;
  localparam state_t RESP   = 2'd3;

endpackage

// File: rtl/mem_port_arbiter_busmux.sv
// Two-way bus multiplexer used to steer the fetch or data address onto the memory port.
module busMux21 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the MEM stage,
// data-first with a bounded wait for fetch, and sequences one access per grant.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              addr_sel,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              if_stall,
  output logic              mem_stall
);

  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam int TMR_W = 8;

  state_t            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              sel_q, sel_d;
  logic              err_q, err_d;
  logic              grant_d;

  // Data wins unless fetch has already waited out STARVE_LIMIT data grants.
  assign grant_d = d_req && (!i_req || (starve_q < SW'(STARVE_LIMIT)));

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    timer_d  = timer_q;
    i_addr_d = i_addr_q;
    d_addr_d = d_addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    sel_d    = sel_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = BUSY_D;
          d_addr_d = d_addr;
          we_d     = d_we;
          wdata_d  = d_wdata;
          sel_d    = 1'b1;
          timer_d  = '0;
          err_d    = 1'b0;
          if (i_req) starve_d = starve_q + SW'(1);
        end else if (i_req) begin
          state_d  = BUSY_I;
          i_addr_d = i_addr;
          sel_d    = 1'b0;
          timer_d  = '0;
          err_d    = 1'b0;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        timer_d = timer_q + TMR_W'(1);
        if (mem_ready) begin
          rdata_d = (state_q == BUSY_D && we_q) ? '0 : mem_rdata;
          state_d = RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      timer_q  <= '0;
      i_addr_q <= '0;
      d_addr_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      sel_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      timer_q  <= timer_d;
      i_addr_q <= i_addr_d;
      d_addr_q <= d_addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
    end
  end

  busMux21 #(.W(ADDR_W)) u_addr_mux (
    .a_i   (i_addr_q),
    .b_i   (d_addr_q),
    .sel_i (sel_q),
    .y_o   (mem_addr)
  );

  // Completion side is decoded from state so reset silences it immediately.
  assign mem_valid = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign mem_we    = (state_q == BUSY_D) && we_q;
  assign mem_wdata = wdata_q;
  assign addr_sel  = sel_q;
  assign i_done    = (state_q == RESP) && !sel_q;
  assign d_done    = (state_q == RESP) && sel_q;
  assign i_rdata   = i_done ? rdata_q : '0;
  assign d_rdata   = d_done ? rdata_q : '0;
  assign err       = (state_q == RESP) && err_q;
  assign if_stall  = i_req && !i_done;
  assign mem_stall = d_req && !d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter: the bench acts as both requesters
// and the memory, and predicts grants from a simple starvation-count model.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 255;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        addr_sel;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        err;
  logic        if_stall;
  logic        mem_stall;

  int total;
  int bad;
  int starve;

  mem_port_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .addr_sel  (addr_sel),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .err       (err),
    .if_stall  (if_stall),
    .mem_stall (mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A hung handshake must still end the run with a visible failure.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic we, input logic [31:0] da, input logic [31:0] wd);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = we;
    d_addr  = da;
    d_wdata = wd;
  endtask

  // Called at the falling edge of an idle cycle with the requests already presented.
  task automatic doAccess(input int delay, input logic [31:0] rd,
                          output logic granted, output logic wonD);
    logic        ir, dr, expD, expWe;
    logic [31:0] expAddr, expWd, expRd;
    ir = i_req;
    dr = d_req;
    granted = ir || dr;
    wonD = 1'b0;
    if (!granted) begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      starve = 0;
      @(negedge clk);
      mem_ready = 1'b0;
      checkOutput("idle_valid", 32'(mem_valid), 32'(0));
      checkOutput("idle_done", 32'({i_done, d_done}), 32'(0));
    end else begin
      expD = dr && (!ir || starve < STARVE_LIMIT);
      if (expD) begin
        if (ir) starve = (starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : starve + 1;
        expAddr = d_addr;
        expWe   = d_we;
        expWd   = d_wdata;
      end else begin
        starve  = 0;
        expAddr = i_addr;
        expWe   = 1'b0;
        expWd   = 32'h0;
      end
      expRd = (expD && expWe) ? 32'h0 : rd;
      @(negedge clk);
      checkOutput("grant_valid", 32'(mem_valid), 32'(1));
      checkOutput("grant_sel", 32'(addr_sel), 32'(expD));
      checkOutput("grant_addr", mem_addr, expAddr);
      checkOutput("grant_we", 32'(mem_we), 32'(expWe));
      if (expD) checkOutput("grant_wdata", mem_wdata, expWd);
      checkOutput("busy_if_stall", 32'(if_stall), 32'(ir));
      checkOutput("busy_mem_stall", 32'(mem_stall), 32'(dr));
      if (expD) begin
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_we    = 1'($urandom_range(0, 1));
      end else begin
        i_addr = $urandom;
      end
      for (int k = 0; k < delay; k++) begin
        @(negedge clk);
        checkOutput("hold_valid", 32'(mem_valid), 32'(1));
        checkOutput("hold_addr", mem_addr, expAddr);
        checkOutput("hold_we", 32'(mem_we), 32'(expWe));
      end
      mem_ready = 1'b1;
      mem_rdata = rd;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      checkOutput("resp_i_done", 32'(i_done), 32'(!expD));
      checkOutput("resp_d_done", 32'(d_done), 32'(expD));
      checkOutput("resp_i_rdata", i_rdata, expD ? 32'h0 : expRd);
      checkOutput("resp_d_rdata", d_rdata, expD ? expRd : 32'h0);
      checkOutput("resp_err", 32'(err), 32'(0));
      checkOutput("resp_valid", 32'(mem_valid), 32'(0));
      checkOutput("resp_if_stall", 32'(if_stall), 32'(ir && expD));
      checkOutput("resp_mem_stall", 32'(mem_stall), 32'(dr && !expD));
      @(negedge clk);
      checkOutput("after_valid", 32'(mem_valid), 32'(0));
      checkOutput("after_done", 32'({i_done, d_done}), 32'(0));
      checkOutput("after_sel", 32'(addr_sel), 32'(expD));
      wonD = expD;
    end
  endtask

  initial begin
    logic g, w;
    int   cnt;
    logic [4:0] wins;
    total = 0;
    bad   = 0;
    starve = 0;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(mem_valid), 32'(0));
    checkOutput("rst_sel", 32'(addr_sel), 32'(0));
    checkOutput("rst_done_err", 32'({i_done, d_done, err}), 32'(0));
    checkOutput("rst_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch alone.
    applyStimulus(1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0, 32'h0);
    doAccess(0, 32'h8C22_0004, g, w);
    checkOutput("if_only_granted_i", 32'(w), 32'(0));
    i_req = 1'b0;

    // Fetch and load together: load first, then fetch.
    applyStimulus(1'b1, 32'h0040_0004, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
    doAccess(1, 32'h1234_5678, g, w);
    checkOutput("simul_first_d", 32'(w), 32'(1));
    d_req = 1'b0;
    doAccess(0, 32'h2002_0001, g, w);
    checkOutput("simul_then_i", 32'(w), 32'(0));

    // Data held continuously: four data grants, then fetch is forced in.
    applyStimulus(1'b1, 32'h0040_0008, 1'b1, 1'b0, 32'h1001_0010, 32'h0);
    for (int n = 0; n < 5; n++) begin
      d_addr = 32'h1001_0010 + 32'(n * 4);
      d_we   = 1'b0;
      doAccess(0, $urandom, g, w);
      wins[n] = w;
    end
    checkOutput("starve_pattern", 32'(wins), 32'b01111);
    doAccess(0, $urandom, g, w);
    checkOutput("starve_cleared", 32'(w), 32'(1));
    i_req = 1'b0;

    // Store returns zero read data.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h1001_0040, 32'hDEAD_BEEF);
    doAccess(2, 32'hFFFF_FFFF, g, w);
    checkOutput("store_is_d", 32'(w), 32'(1));

    // Timeout on a load that never completes.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h1001_0080, 32'h0);
    mem_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    checkOutput("to_grant_valid", 32'(mem_valid), 32'(1));
    cnt = 0;
    while (!d_done && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("to_cycles", 32'(cnt), 32'(TIMEOUT));
    checkOutput("to_err", 32'(err), 32'(1));
    checkOutput("to_rdata", d_rdata, 32'h0);
    checkOutput("to_valid", 32'(mem_valid), 32'(0));
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("to_idle_valid", 32'(mem_valid), 32'(0));
    checkOutput("to_idle_err", 32'(err), 32'(0));

    // Randomized traffic; a pending loser always keeps its request.
    for (int it = 0; it < 80; it++) begin
      doAccess(int'($urandom_range(0, 3)), $urandom, g, w);
      if (!g) begin
        applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom, $urandom);
      end else if (w) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
        if (!i_req) begin
          i_req  = 1'($urandom_range(0, 1));
          i_addr = $urandom;
        end
      end else begin
        i_req  = 1'($urandom_range(0, 1));
        i_addr = $urandom;
        if (!d_req) begin
          d_req   = 1'($urandom_range(0, 1));
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = $urandom;
          d_wdata = $urandom;
        end
      end
    end

    // Asynchronous reset in the middle of a data access.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h1001_00C0, 32'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("mid_busy_valid", 32'(mem_valid), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(mem_valid), 32'(0));
    checkOutput("mid_rst_sel", 32'(addr_sel), 32'(0));
    checkOutput("mid_rst_done_err", 32'({i_done, d_done, err}), 32'(0));
    starve = 0;
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_idle", 32'(mem_valid), 32'(0));
    applyStimulus(1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0, 32'h0);
    doAccess(1, 32'h0BAD_F00D, g, w);
    checkOutput("post_rst_access_i", 32'(w), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
